sender_credit_arb: RTL and testbench
====================================

SENDER_CREDIT_ARB -- requirements
Module: sender_credit_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of requesters sharing the outgoing link.
REQ-002 SHALL have parameter CREDITS, default 8: initial and maximum credit count, matching the receiver buffer depth.
REQ-003 SHALL have parameter CREDIT_W, default 4: width of the credit counter, which SHALL hold the value CREDITS.
REQ-004 SHALL have port clk_i  input  1  clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid_i  input  NUM_REQ  per-requester flit valid.
REQ-007 SHALL have port req_data_i  input  NUM_REQ x 64  per-requester flit.
REQ-008 SHALL have port req_ready_o  output  NUM_REQ  per-requester flit accepted this cycle when ANDed with valid.
REQ-009 SHALL have port valid_o  output  1  link flit valid.
REQ-010 SHALL have port data_o  output  64  link flit.
REQ-011 SHALL have port yummy_i  input  1  one credit returned by the receiver.
REQ-012 SHALL have port credit_o  output  CREDIT_W  current credit count.
REQ-013 SHALL have port grant_o  output  NUM_REQ  one-hot current owner, all-zero when idle.
REQ-014 SHALL have port err_o  output  1  credit overflow flag, present only under REQ-031.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and LOCKED; packets SHALL never interleave on the link.
REQ-016 In IDLE, SHALL grant the first requester with valid asserted, searching round-robin from index (last_winner+1) mod NUM_REQ.
REQ-017 SHALL accept a flit only when the granted requester has valid asserted and credit_q > 0.
REQ-018 req_ready_o[i] SHALL be combinational, equal to grant[i] AND (credit_q > 0).
REQ-019 In IDLE, the accepted flit SHALL be a header carrying payload length in bits [29:22]; the FSM SHALL load remaining = length.
REQ-020 If length = 0, SHALL stay in IDLE and update last_winner.
REQ-021 If length > 0, SHALL enter LOCKED, holding grant_o on the winner.
REQ-022 In LOCKED, each accepted flit SHALL decrement remaining; on the 1->0 transition SHALL return to IDLE and set last_winner to the owner.
REQ-023 valid_o and data_o SHALL be registered: an accepted flit appears exactly 1 cycle after acceptance, with valid_o high for 1 cycle per flit.
REQ-024 SHALL set credit_d = credit_q - accept + yummy_i; an accept and a yummy in the same cycle SHALL leave the count unchanged.
REQ-025 At credit_q = 0, SHALL deassert every ready, keep the FSM state, remaining and grant, and resume on the first yummy.
REQ-026 A yummy_i arriving at credit_q = CREDITS SHALL saturate (count stays CREDITS).
REQ-027 Owner valid deasserted mid-packet SHALL leave the block in LOCKED and send no flit that cycle.

Reset
REQ-028 On rstn_i low, SHALL immediately set: credit_q = CREDITS, FSM = IDLE, remaining = 0, last_winner = NUM_REQ-1, valid_o = 0, data_o = 0, grant_o = 0, err_o = 0.
REQ-029 Reset asserted mid-packet SHALL abandon the packet; after release, arbitration SHALL restart at requester 0.
REQ-030 All ready outputs SHALL be 0 during reset.

Configuration
REQ-031 With macro SENDER_CREDIT_ARB_CHECK_EN defined, SHALL provide err_o, set sticky-high on any yummy at credit_q = CREDITS with no accept in the same cycle (cleared only by reset), and SHALL $display an error message; without the macro, err_o and the check SHALL be absent and saturation per REQ-026 SHALL still apply.

Verification
REQ-032 Req0 sends header len=2 plus 2 flits, with yummy returned each cycle -> valid_o high cycles 1-3 after the first accept, data in order, credit_o returns to 8.
REQ-033 Req0 and req1 both valid with len=0 headers, back-to-back -> grants alternate 0,1,0,1.
REQ-034 Req0 sends len=10 with no yummy -> exactly 8 flits accepted, ready low, credit_o=0; one yummy -> one more flit.
REQ-035 Req1 valid during req0's len=3 packet -> no req1 flit appears until all 4 req0 flits have been sent.
REQ-036 Accept and yummy in the same cycle at credit 5 -> credit stays 5; yummy at credit 8 -> credit stays 8, err_o=1 when the macro is defined.
REQ-037 rstn_i pulsed low mid-packet -> valid_o=0, grant_o=0 and credit_o=8 immediately; the next header is granted to req0.

Source files
------------

// File: rtl/sender_credit_arb_if.sv
// Link-side bundle for sender_credit_arb: requester handshakes, outgoing flit link and credit return.
// err_o exists only when SENDER_CREDIT_ARB_CHECK_EN is defined.
interface sender_credit_arb_if #(
    parameter int NUM_REQ  = 3,
    parameter int CREDIT_W = 4
);
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0][63:0]  req_data_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic                      valid_o;
    logic [63:0]               data_o;
    logic                      yummy_i;
    logic [CREDIT_W-1:0]       credit_o;
    logic [NUM_REQ-1:0]        grant_o;
`ifdef SENDER_CREDIT_ARB_CHECK_EN
    logic                      err_o;

    modport master (
        output req_valid_i, req_data_i, yummy_i,
        input  req_ready_o, valid_o, data_o, credit_o, grant_o, err_o
    );
    modport slave (
        input  req_valid_i, req_data_i, yummy_i,
        output req_ready_o, valid_o, data_o, credit_o, grant_o, err_o
    );
`else
    modport master (
        output req_valid_i, req_data_i, yummy_i,
        input  req_ready_o, valid_o, data_o, credit_o, grant_o
    );
    modport slave (
        input  req_valid_i, req_data_i, yummy_i,
        output req_ready_o, valid_o, data_o, credit_o, grant_o
    );
`endif
endinterface

// File: rtl/sender_credit_arb.sv
// Credit-based, packet-locking round-robin arbiter driving one registered flit link.
// Optional credit-overflow checker enabled by macro SENDER_CREDIT_ARB_CHECK_EN (adds err_o).
module sender_credit_arb #(
    parameter int NUM_REQ  = 3,
    parameter int CREDITS  = 8,
    parameter int CREDIT_W = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    sender_credit_arb_if.slave    bus
);
    localparam int                  IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(CREDITS);
    localparam logic [IDX_W-1:0]    LAST_INIT  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e               state_r;
    state_e               state_s;
    logic [IDX_W-1:0]     owner_r;
    logic [IDX_W-1:0]     last_r;
    logic [7:0]           remaining_r;
    logic [CREDIT_W-1:0]  credit_r;
    logic [CREDIT_W-1:0]  credit_s;
    logic                 valid_r;
    logic [63:0]          data_r;

    logic [IDX_W-1:0]     pick_idx_s;
    logic                 pick_hit_s;
    logic [IDX_W-1:0]     sel_idx_s;
    logic [NUM_REQ-1:0]   grant_s;
    logic [NUM_REQ-1:0]   ready_s;
    logic                 accept_s;
    logic [63:0]          sel_data_s;
    logic [7:0]           hdr_len_s;
    int                   cand_s;

    // Round-robin search starting just after the last packet's winner
    always_comb begin
        pick_idx_s = '0;
        pick_hit_s = 1'b0;
        cand_s     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = int'(last_r) + 1 + k;
            if (cand_s >= NUM_REQ) begin
                cand_s = cand_s - NUM_REQ;
            end else begin
                cand_s = cand_s;
            end
            if (!pick_hit_s && bus.req_valid_i[IDX_W'(cand_s)]) begin
                pick_hit_s = 1'b1;
                pick_idx_s = IDX_W'(cand_s);
            end else begin
                pick_hit_s = pick_hit_s;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: lock on a non-empty header, release on the last payload flit
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (hdr_len_s != 8'd0)) begin
                    state_s = ST_LOCKED;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (accept_s && (remaining_r <= 8'd1)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_LOCKED;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: grant, ready and the accepted-flit mux (all quiet while in reset)
    always_comb begin
        grant_s   = '0;
        sel_idx_s = '0;
        if (!rstn_i) begin
            grant_s   = '0;
            sel_idx_s = '0;
        end else if (state_r == ST_LOCKED) begin
            sel_idx_s          = owner_r;
            grant_s[owner_r]   = 1'b1;
        end else if (pick_hit_s) begin
            sel_idx_s          = pick_idx_s;
            grant_s[pick_idx_s] = 1'b1;
        end else begin
            grant_s   = '0;
            sel_idx_s = '0;
        end
        ready_s    = (credit_r != '0) ? grant_s : '0;
        accept_s   = |(ready_s & bus.req_valid_i);
        sel_data_s = bus.req_data_i[sel_idx_s];
        hdr_len_s  = sel_data_s[29:22];
    end

    // Packet bookkeeping: owner, flits still owed, and the round-robin pointer
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            owner_r     <= '0;
            last_r      <= LAST_INIT;
            remaining_r <= 8'd0;
        end else if (accept_s) begin
            if (state_r == ST_IDLE) begin
                remaining_r <= hdr_len_s;
                if (hdr_len_s == 8'd0) begin
                    last_r <= pick_idx_s;
                end else begin
                    owner_r <= pick_idx_s;
                end
            end else begin
                remaining_r <= remaining_r - 8'd1;
                if (remaining_r <= 8'd1) begin
                    last_r <= owner_r;
                end
            end
        end
    end

    // Credit update; a returned credit at the maximum is dropped
    always_comb begin
        credit_s = credit_r;
        if (accept_s && !bus.yummy_i) begin
            credit_s = credit_r - {{(CREDIT_W-1){1'b0}}, 1'b1};
        end else if (!accept_s && bus.yummy_i && (credit_r != CREDIT_MAX)) begin
            credit_s = credit_r + {{(CREDIT_W-1){1'b0}}, 1'b1};
        end else begin
            credit_s = credit_r;
        end
    end

    // Credit counter and registered link output
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            credit_r <= CREDIT_MAX;
            valid_r  <= 1'b0;
            data_r   <= 64'd0;
        end else begin
            credit_r <= credit_s;
            valid_r  <= accept_s;
            if (accept_s) begin
                data_r <= sel_data_s;
            end
        end
    end

`ifdef SENDER_CREDIT_ARB_CHECK_EN
    logic err_r;
    logic overflow_s;

    // A credit returned while already full means the receiver and sender disagree
    always_comb begin
        overflow_s = bus.yummy_i && !accept_s && (credit_r == CREDIT_MAX);
    end

    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_r <= 1'b0;
        end else if (overflow_s) begin
            err_r <= 1'b1;
            $display("ERROR: sender_credit_arb credit overflow (yummy at full credit) at %0t", $time);
        end
    end

    assign bus.err_o = err_r;
`endif

    assign bus.req_ready_o = ready_s;
    assign bus.grant_o     = grant_s;
    assign bus.valid_o     = valid_r;
    assign bus.data_o      = data_r;
    assign bus.credit_o    = credit_r;

endmodule

// File: tb/tb_sender_credit_arb.sv
// Directed bench for sender_credit_arb: per-cycle vector table plus hand sequences for
// credit exhaustion, mid-packet reset and credit saturation.
module tb_sender_credit_arb;
    logic clk;
    logic rstn;
    int   errors;
    int   checks;

    sender_credit_arb_if #(.NUM_REQ(3), .CREDIT_W(4)) bus ();

    sender_credit_arb #(.NUM_REQ(3), .CREDITS(8), .CREDIT_W(4)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  vld;
        logic        yum;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [2:0]  rdy;
        logic [2:0]  gnt;
        logic        vo;
        logic [31:0] dout;
        logic [3:0]  crd;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [2:0] vld, input logic yum, input logic [31:0] d0,
                                input logic [31:0] d1, input logic [2:0] rdy, input logic [2:0] gnt,
                                input logic vo, input logic [31:0] dout, input logic [3:0] crd);
        vec_t v;
        v.vld = vld; v.yum = yum; v.d0 = d0; v.d1 = d1; v.rdy = rdy;
        v.gnt = gnt; v.vo = vo; v.dout = dout; v.crd = crd;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [31:0] a, input logic [31:0] b, input logic y);
        bus.req_valid_i    = v;
        bus.req_data_i[0]  = {32'h0, a};
        bus.req_data_i[1]  = {32'h0, b};
        bus.req_data_i[2]  = 64'h0;
        bus.yummy_i        = y;
    endtask

    // One cycle: apply inputs on the falling edge, sample just after
    task automatic cyc(input logic [2:0] v, input logic [31:0] a, input logic [31:0] b, input logic y);
        @(negedge clk);
        drive(v, a, b, y);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sent;
        int vo_cnt;
        errors = 0;
        checks = 0;

        // Headers: length in bits [29:22]
        add(3'b001, 1'b1, 32'h0080_0001, 32'h0, 3'b001, 3'b001, 1'b0, 32'h0,          4'd8);
        add(3'b001, 1'b1, 32'h0000_0011, 32'h0, 3'b001, 3'b001, 1'b1, 32'h0080_0001, 4'd8);
        add(3'b001, 1'b1, 32'h0000_0012, 32'h0, 3'b001, 3'b001, 1'b1, 32'h0000_0011, 4'd8);
        add(3'b000, 1'b0, 32'h0, 32'h0,         3'b000, 3'b000, 1'b1, 32'h0000_0012, 4'd8);
        add(3'b000, 1'b0, 32'h0, 32'h0,         3'b000, 3'b000, 1'b0, 32'h0000_0012, 4'd8);
        add(3'b001, 1'b0, 32'h00C0_0002, 32'h0, 3'b001, 3'b001, 1'b0, 32'h0000_0012, 4'd8);
        add(3'b011, 1'b0, 32'h21, 32'h31,       3'b001, 3'b001, 1'b1, 32'h00C0_0002, 4'd7);
        add(3'b011, 1'b0, 32'h22, 32'h31,       3'b001, 3'b001, 1'b1, 32'h21,        4'd6);
        add(3'b010, 1'b0, 32'h0,  32'h31,       3'b001, 3'b001, 1'b1, 32'h22,        4'd5);
        add(3'b011, 1'b0, 32'h23, 32'h31,       3'b001, 3'b001, 1'b0, 32'h22,        4'd5);
        add(3'b010, 1'b0, 32'h0,  32'h31,       3'b010, 3'b010, 1'b1, 32'h23,        4'd4);
        add(3'b000, 1'b0, 32'h0,  32'h0,        3'b000, 3'b000, 1'b1, 32'h31,        4'd3);
        add(3'b011, 1'b1, 32'h41, 32'h51,       3'b001, 3'b001, 1'b0, 32'h31,        4'd3);
        add(3'b011, 1'b1, 32'h41, 32'h51,       3'b010, 3'b010, 1'b1, 32'h41,        4'd3);
        add(3'b011, 1'b1, 32'h41, 32'h51,       3'b001, 3'b001, 1'b1, 32'h51,        4'd3);
        add(3'b011, 1'b1, 32'h41, 32'h51,       3'b010, 3'b010, 1'b1, 32'h41,        4'd3);
        add(3'b000, 1'b1, 32'h0,  32'h0,        3'b000, 3'b000, 1'b1, 32'h51,        4'd3);
        add(3'b000, 1'b0, 32'h0,  32'h0,        3'b000, 3'b000, 1'b0, 32'h51,        4'd4);

        // Reset with all requesters valid: nothing may be granted or ready
        rstn = 1'b0;
        drive(3'b111, 32'h0080_0001, 32'h0080_0002, 1'b0);
        @(negedge clk);
        #1;
        chk("rst ready",  64'(bus.req_ready_o), 64'd0);
        chk("rst grant",  64'(bus.grant_o),     64'd0);
        chk("rst valid",  64'(bus.valid_o),     64'd0);
        chk("rst data",   bus.data_o,           64'd0);
        chk("rst credit", 64'(bus.credit_o),    64'd8);
`ifdef SENDER_CREDIT_ARB_CHECK_EN
        chk("rst err",    64'(bus.err_o),       64'd0);
`endif
        @(negedge clk);
        rstn = 1'b1;
        drive(3'b000, 32'h0, 32'h0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].vld, tbl[i].d0, tbl[i].d1, tbl[i].yum);
            chk($sformatf("row%0d ready", i),  64'(bus.req_ready_o), 64'(tbl[i].rdy));
            chk($sformatf("row%0d grant", i),  64'(bus.grant_o),     64'(tbl[i].gnt));
            chk($sformatf("row%0d valid", i),  64'(bus.valid_o),     64'(tbl[i].vo));
            chk($sformatf("row%0d data", i),   bus.data_o,           {32'h0, tbl[i].dout});
            chk($sformatf("row%0d credit", i), 64'(bus.credit_o),    64'(tbl[i].crd));
        end

        // Refill credits to 8, then a len=10 packet with no credit return
        for (int i = 0; i < 4; i++) cyc(3'b000, 32'h0, 32'h0, 1'b1);
        sent   = 0;
        vo_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            cyc(3'b001, (sent == 0) ? 32'h0280_000A : 32'h100 + 32'(sent), 32'h0, 1'b0);
            if (c == 0) chk("refill credit", 64'(bus.credit_o), 64'd8);
            if (bus.valid_o) vo_cnt++;
            if (bus.req_ready_o[0]) sent++;
        end
        chk("starved accepts", 64'(sent),             64'd8);
        chk("starved flits",   64'(vo_cnt),           64'd8);
        chk("starved ready",   64'(bus.req_ready_o),  64'd0);
        chk("starved credit",  64'(bus.credit_o),     64'd0);
        chk("starved grant",   64'(bus.grant_o),      64'b001);
        chk("starved data",    bus.data_o,            64'h107);
        cyc(3'b001, 32'h108, 32'h0, 1'b1);
        chk("yummy cycle ready", 64'(bus.req_ready_o), 64'd0);
        cyc(3'b001, 32'h108, 32'h0, 1'b0);
        chk("resume credit", 64'(bus.credit_o),    64'd1);
        chk("resume ready",  64'(bus.req_ready_o), 64'b001);
        cyc(3'b001, 32'h109, 32'h0, 1'b0);
        chk("resume valid",  64'(bus.valid_o),     64'd1);
        chk("resume data",   bus.data_o,           64'h108);
        chk("drain credit",  64'(bus.credit_o),    64'd0);
        chk("drain ready",   64'(bus.req_ready_o), 64'd0);

        // Reset mid-packet takes effect at once
        rstn = 1'b0;
        #1;
        chk("midrst valid",  64'(bus.valid_o),     64'd0);
        chk("midrst grant",  64'(bus.grant_o),     64'd0);
        chk("midrst credit", 64'(bus.credit_o),    64'd8);
        chk("midrst ready",  64'(bus.req_ready_o), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        drive(3'b000, 32'h0, 32'h0, 1'b0);

        // Arbitration restarts at requester 0; then credit accounting corners
        cyc(3'b011, 32'h61, 32'h71, 1'b0);
        chk("post-rst grant", 64'(bus.grant_o),     64'b001);
        chk("post-rst ready", 64'(bus.req_ready_o), 64'b001);
        cyc(3'b001, 32'h62, 32'h0, 1'b0);
        chk("post-rst data",  bus.data_o,           64'h61);
        chk("post-rst credit", 64'(bus.credit_o),   64'd7);
        cyc(3'b001, 32'h63, 32'h0, 1'b0);
        cyc(3'b001, 32'h64, 32'h0, 1'b1);
        chk("credit at 5", 64'(bus.credit_o), 64'd5);
        cyc(3'b000, 32'h0, 32'h0, 1'b0);
        chk("acc+yummy credit", 64'(bus.credit_o), 64'd5);
        chk("acc+yummy data",   bus.data_o,        64'h64);
        for (int i = 0; i < 3; i++) cyc(3'b000, 32'h0, 32'h0, 1'b1);
        cyc(3'b000, 32'h0, 32'h0, 1'b1);
        chk("full credit", 64'(bus.credit_o), 64'd8);
`ifdef SENDER_CREDIT_ARB_CHECK_EN
        chk("err before overflow", 64'(bus.err_o), 64'd0);
`endif
        cyc(3'b000, 32'h0, 32'h0, 1'b0);
        chk("saturated credit", 64'(bus.credit_o), 64'd8);
`ifdef SENDER_CREDIT_ARB_CHECK_EN
        chk("err after overflow", 64'(bus.err_o), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
